main_memory_ctrl: RTL and testbench
===================================

Name: main_memory_ctrl

Overview:
Parametrised, handshaked data memory for the processor's load/store path. It is the successor to the fixed 1024x16 single-cycle memory. Adds:
- configurable width and depth
- programmable wait states
- valid/ready request and response channels
- an out-of-range error flag
- a sequential clear sweep after reset, replacing the single-cycle bulk clear

The processor's load/store unit drives the request channel and stalls on the response channel.

Parameters:
DATA_W, 16, data word width in bits (signed two's complement)
ADDR_W, 10, address width in bits
DEPTH, 1024, number of implemented words; must be <= 2**ADDR_W
WAIT_STATES, 2, extra access cycles before response; legal range 0..15
CLEAR_ON_RESET, 1, 1 = zero all words via sweep after reset; 0 = skip sweep, contents undefined

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  block accepts request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  signed store data
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  DATA_W  signed load data, or echoed store data
rsp_err  output  1  address was >= DEPTH
init_done  output  1  clear sweep finished; memory usable

Behaviour:
- Reset low (asynchronous) sets:
  - state = CLEAR if CLEAR_ON_RESET, else IDLE
  - clr_ptr = 0; wait counter = 0
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
  - init_done = 0, or 1 when CLEAR_ON_RESET = 0
  - req_ready = 0 while reset is low
- Memory array has no reset port. Clearing is done only by the sweep.
- States are CLEAR, IDLE, WAIT, RESP. req_ready = (state == IDLE), decoded combinationally from the registered state.
- CLEAR:
  - Writes 0 to word clr_ptr each cycle and increments clr_ptr.
  - After writing word DEPTH-1: init_done <= 1, next state IDLE.
  - The sweep takes exactly DEPTH cycles. Requests are ignored and not accepted.
- IDLE: on req_valid && req_ready at edge T:
  - latch we, addr, wdata
  - cnt <= WAIT_STATES
  - next state WAIT
- WAIT:
  - If cnt != 0: cnt decrements each cycle.
  - If cnt == 0, the access executes at that edge and the next state is RESP, with rsp_valid <= 1.
  - Load: rsp_rdata <= mem[addr].
  - Store: mem[addr] <= wdata; rsp_rdata <= wdata.
  - Out of range (addr >= DEPTH): no array access; rsp_rdata <= 0, rsp_err <= 1.
  - In range: rsp_err <= 0.
- Latency: rsp_valid rises WAIT_STATES+1 cycles after the accept edge T. With WAIT_STATES = 0 it is high in the cycle after acceptance.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready.
  - On the rsp_valid && rsp_ready edge: rsp_valid <= 0, next state IDLE.
  - rsp_rdata and rsp_err keep their last values after the handshake.
- Single outstanding transaction. A new request is accepted one cycle after the response handshake, never in the same cycle. Peak throughput is one access per WAIT_STATES+3 cycles.
- Request inputs are sampled only at the accept edge. Changes to them during WAIT or RESP have no effect.
- Reset mid-operation:
  - A WAIT-state store that has not reached its execute edge is discarded.
  - A response in RESP is dropped.
  - The sweep restarts from word 0.
- Store then load to the same address returns the stored value, since the store commits before its response.
- Data is treated as signed only for interpretation. No arithmetic is performed; values pass bit-exact.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, DEPTH=1024 -> req_ready=0 and init_done=0 for 1024 cycles, then init_done=1 and req_ready=1. Load from addr 0x3FF -> rsp_rdata=0x0000, rsp_err=0.
- WAIT_STATES=2: store 0x8001 to addr 5 accepted at edge T -> rsp_valid rises after edge T+3 with rsp_rdata=0x8001. Then load addr 5 -> rsp_rdata=0x8001 (-32767).
- Response backpressure: hold rsp_ready=0 for 10 cycles after a load of addr 7 (value 0x1234) -> rsp_valid stays 1, rsp_rdata stays 0x1234, req_ready stays 0. Raise rsp_ready -> rsp_valid=0 next cycle, req_ready=1.
- DEPTH=1000, ADDR_W=10: store 0x7777 to addr 1000 -> rsp_err=1, rsp_rdata=0. Subsequent loads of addrs 0..999 show no corruption.
- Reset mid-op: store 0x5555 to addr 3 accepted with WAIT_STATES=4, reset low at cycle 2 of WAIT -> rsp_valid=0 immediately. After re-sweep, load addr 3 -> 0x0000.
- WAIT_STATES=0, back-to-back requests with req_valid held high and rsp_ready=1 -> accepts spaced exactly 3 cycles apart, each response 1 cycle after accept.

Source files
------------

// File: rtl/main_memory_ctrl.sv
// Handshaked single-port data memory for the load/store path.
// Post-reset zero sweep, programmable wait states and an out-of-range error flag.
module main_memory_ctrl #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned WAIT_STATES    = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              init_done_o
);

  typedef enum logic [1:0] {StClear, StIdle, StWait, StResp} state_e;

  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        WaitInit = 4'(WAIT_STATES);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                init_done_q, init_done_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                in_range;
  logic                exec;

  assign in_range = ({1'b0, addr_q} < DepthW);
  assign exec     = (state_q == StWait) && (cnt_q == 4'd0);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR_ON_RESET ? StClear : StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear: if (clr_ptr_q == LastIdx) state_d = StIdle;
      StIdle:  if (req_valid_i)          state_d = StWait;
      StWait:  if (cnt_q == 4'd0)        state_d = StResp;
      StResp:  if (rsp_ready_i)          state_d = StIdle;
      default:                           state_d = StIdle;
    endcase
  end

  // Outputs; req_ready is forced low while reset is asserted
  always_comb begin
    req_ready_o = rst_ni && (state_q == StIdle);
    rsp_valid_o = rsp_valid_q;
    rsp_rdata_o = rsp_rdata_q;
    rsp_err_o   = rsp_err_q;
    init_done_o = init_done_q;
  end

  // Datapath next-state
  always_comb begin
    clr_ptr_d   = clr_ptr_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    init_done_d = init_done_q;
    unique case (state_q)
      StClear: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LastIdx) init_done_d = 1'b1;
      end
      StIdle: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          cnt_d   = WaitInit;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = !in_range;
          if (!in_range)  rsp_rdata_d = '0;
          else if (we_q)  rsp_rdata_d = wdata_q;
          else            rsp_rdata_d = mem_q[addr_q];
        end
      end
      StResp: if (rsp_ready_i) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clr_ptr_q   <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      init_done_q <= !CLEAR_ON_RESET;
    end else begin
      clr_ptr_q   <= clr_ptr_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      init_done_q <= init_done_d;
    end
  end

  // Array write port shared by the clear sweep and committed stores
  always_comb begin
    mem_we    = (state_q == StClear) || (exec && we_q && in_range);
    mem_waddr = (state_q == StClear) ? clr_ptr_q : addr_q;
    mem_wdata = (state_q == StClear) ? '0 : wdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboard bench for main_memory_ctrl: random load/store traffic against an array model,
// plus directed sweep, backpressure, out-of-range and mid-operation reset scenarios.
module tb_main_memory_ctrl;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1000;
  localparam int unsigned WS    = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          init_done_o;

  main_memory_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_STATES(WS), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .init_done_o(init_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    int unsigned   acc;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [1024];
  int unsigned   cyc = 0;
  int            checks = 0;
  int            errors = 0;
  bit            stall = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Consumer side: random rsp_ready unless stalled
  initial forever begin
    @(posedge clk_i);
    #1;
    rsp_ready_i = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Reference: plain word array, updated when a request is accepted
  task automatic model_push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.acc = cyc + 1;
    if (int'(a) >= int'(DEPTH)) begin
      e.rdata = '0;
      e.err   = 1'b1;
    end else begin
      e.err = 1'b0;
      if (we) ref_mem[a] = d;
      e.rdata = ref_mem[a];
    end
    exp_q.push_back(e);
  endtask

  // Entered at posedge+1; returns at posedge+1 just after the accept edge
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit track);
    int n;
    n = 0;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = a;
    req_wdata_i = d;
    forever begin
      @(negedge clk_i);
      if (req_ready_o) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: req_ready stayed 0, expected 1 within 300 cycles");
        break;
      end
    end
    if (track && n <= 300) model_push(we, a, d);
    @(posedge clk_i);
    #1;
    // Scramble request fields after acceptance; they must be ignored
    req_valid_i = 1'b0;
    req_we_i    = 1'($urandom);
    req_addr_i  = AW'($urandom);
    req_wdata_i = DW'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk_i);
    #1;
  endtask

  // Monitor
  bit            prev_valid = 1'b0;
  bit            prev_hs = 1'b0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;

  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_ni) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      last_rdata = '0;
      last_err   = 1'b0;
    end else begin
      if (prev_hs) begin
        chk("post_hs_req_ready", req_ready_o, 1);
        chk("post_hs_rsp_valid", rsp_valid_o, 0);
        chk("post_hs_rdata_kept", rsp_rdata_o, last_rdata);
        chk("post_hs_err_kept", rsp_err_o, last_err);
      end
      if (rsp_valid_o) begin
        chk("req_ready_low_in_resp", req_ready_o, 0);
        if (!prev_valid) begin
          chk("rsp_was_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("latency", cyc - exp_q[0].acc, WS + 1);
        end else begin
          chk("hold_rdata", rsp_rdata_o, last_rdata);
          chk("hold_err", rsp_err_o, last_err);
        end
        if (rsp_ready_i && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata_o, e.rdata);
          chk("rsp_err", rsp_err_o, e.err);
        end
        last_rdata = rsp_rdata_o;
        last_err   = rsp_err_o;
      end
      prev_valid = rsp_valid_o && !rsp_ready_i;
      prev_hs    = rsp_valid_o && rsp_ready_i;
    end
  end

  task automatic sweep_check();
    bit bad;
    bad = 1'b0;
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    for (int k = 1; k <= int'(DEPTH); k++) begin
      @(negedge clk_i);
      if (k < int'(DEPTH)) begin
        if (init_done_o || req_ready_o) bad = 1'b1;
      end else begin
        chk("sweep_init_done_at_depth", init_done_o, 1);
        chk("sweep_req_ready_at_depth", req_ready_o, 1);
      end
    end
    chk("sweep_busy_flags_low", bad, 0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_rdata", rsp_rdata_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_init_done", init_done_o, 0);
    sweep_check();

    // Boundary loads after sweep
    issue(1'b0, 10'd999, '0, 1'b1);
    issue(1'b0, 10'd1023, '0, 1'b1);
    // Negative value round-trip
    issue(1'b1, 10'd5, 16'h8001, 1'b1);
    issue(1'b0, 10'd5, '0, 1'b1);
    issue(1'b1, 10'd7, 16'h1234, 1'b1);
    drain();

    // Backpressure on a load
    stall = 1'b1;
    @(posedge clk_i);
    #1;
    issue(1'b0, 10'd7, '0, 1'b1);
    repeat (14) @(negedge clk_i);
    chk("bp_rsp_valid", rsp_valid_o, 1);
    chk("bp_rsp_rdata", rsp_rdata_o, 32'h1234);
    chk("bp_req_ready", req_ready_o, 0);
    @(posedge clk_i);
    #1 stall = 1'b0;
    drain();

    // Out-of-range store must not alias into the array
    issue(1'b1, 10'd1000, 16'h7777, 1'b1);
    issue(1'b1, 10'd1023, 16'h7777, 1'b1);

    for (int t = 0; t < 300; t++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 1023));
      issue(1'($urandom), a, DW'($urandom), 1'b1);
    end
    drain();

    // Reset in the middle of a store's wait period
    issue(1'b1, 10'd3, 16'h1111, 1'b1);
    drain();
    issue(1'b1, 10'd3, 16'h5555, 1'b0);
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid_o, 0);
    chk("midrst_req_ready", req_ready_o, 0);
    chk("midrst_init_done", init_done_o, 0);
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk_i);
    sweep_check();
    issue(1'b0, 10'd3, '0, 1'b1);

    // Readback of every implemented word
    for (int i = 0; i < int'(DEPTH); i++) issue(1'b0, AW'(i), '0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
